wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage directly upstream of the register file. Merges single-cycle ALU results and stallable load-unit results into one registered write port that drives the register file's `reg_write`, `write_register` and `write_data` inputs. A 32-bit pending-register scoreboard tells decode which source registers are not yet safe to read.

## Interface
- `XLEN`, 32: data width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `issue_valid` in 1: an instruction writing `issue_rd` is issued this cycle.
- `issue_rd` in 5: destination of the issued instruction.
- `alu_valid` in 1: ALU result present. Always accepted; there is no ready signal.
- `alu_rd` in 5: ALU destination.
- `alu_data` in XLEN: ALU result.
- `mem_valid` in 1: load result present.
- `mem_ready` out 1: load result accepted when `mem_valid && mem_ready`.
- `mem_rd` in 5: load destination.
- `mem_data` in XLEN: load result.
- `rs1`, `rs2` in 5: decode source registers to check.
- `busy_rs1`, `busy_rs2` out 1: source register is not readable from the regfile this cycle.
- `reg_write` out 1: write strobe to the regfile.
- `write_register` out 5: write address.
- `write_data` out XLEN: write data.
- `fwd_rs1_valid`, `fwd_rs2_valid` out 1: forward valid. Present only with `WB_BYPASS_EN`.
- `fwd_rs1_data`, `fwd_rs2_data` out XLEN: forward data. Present only with `WB_BYPASS_EN`.

## Operation
- Reset values:
  - `reg_write`=0, `write_register`=0, `write_data`=0.
  - Skid buffer empty, so `mem_ready`=1.
  - Scoreboard all clear, so `busy_*`=0.
  - `fwd_*`=0.
- Skid buffer:
  - 2-entry FIFO for accepted load results; entries hold `{rd, data}`.
  - `mem_ready` = occupancy < 2. It is combinational on occupancy only, never on `mem_valid`.
- Output-register select, evaluated each cycle in priority order:
  1. `alu_valid` selects the ALU result.
  2. Otherwise the skid-buffer head, which is popped.
  3. Otherwise an accepted load with an empty buffer, which passes straight through.
  4. Otherwise nothing; `reg_write` is 0 next cycle.
- When an ALU result and a load arrive together, the ALU wins and the load is pushed into the buffer.
- Pushes and pops:
  - A push and a pop in the same cycle leave occupancy unchanged.
  - If the buffer is empty, a load with no ALU competition is not pushed.
- `rd`=0 handling:
  - Any result with `rd`=0 still consumes its slot (load handshake, buffer entry, select cycle).
  - It produces `reg_write`=0.
  - It never touches the scoreboard.
- Scoreboard bit `sb[r]`:
  - Set at the edge where `issue_valid && issue_rd==r && r!=0`.
  - Cleared at the edge where a result for `r` is loaded into the output register.
  - When set and clear for the same `r` coincide, set wins, because the issue is newer.
  - `sb[0]` is constantly 0.
- `busy_rsN` (combinational) = `rsN!=0 && (sb[rsN] || (reg_write && write_register==rsN))`. The second term disappears under `WB_BYPASS_EN`.
- Write-after-write ordering across ports is decode's responsibility: decode does not issue to a busy `rd`.

## Timing
- Latency:
  - ALU result to regfile write: 1 cycle. `reg_write` is high in the cycle after `alu_valid`, and the regfile captures it at the following edge.
  - Load result with empty buffer and no ALU: 1 cycle.
  - A buffered load waits one cycle for each cycle in which `alu_valid` is high.
- Throughput: one write per cycle. Sustained ALU traffic starves loads. `mem_ready` falls after 2 stalled loads and rises in the cycle after a pop.
- Reset mid-operation:
  - Buffered loads are discarded.
  - Pending scoreboard bits clear.
  - A write in flight is dropped; `reg_write` goes to 0 immediately, asynchronously.

## Configuration
- `WB_BYPASS_EN` defined:
  - `fwd_rsN_valid` = `reg_write && write_register==rsN && rsN!=0`.
  - `fwd_rsN_data` = `write_data`.
  - `busy_rsN` excludes the in-flight term, so decode reads the forwarded value instead of stalling.
- `WB_BYPASS_EN` undefined:
  - The forward ports are absent.
  - `busy_rsN` includes the in-flight term, giving one extra stall cycle on a read directly after a write.

## Test plan
- Reset, then ALU result `rd`=5, data 0xDEADBEEF for one cycle → next cycle `reg_write`=1, `write_register`=5, `write_data`=0xDEADBEEF; the cycle after that `reg_write`=0.
- Issue `rd`=7, load `rd`=7 data 0x1234 two cycles later → `busy_rs1` (rs1=7) high from the cycle after issue until the write.
  - Bypass off: busy until the cycle after `reg_write`.
  - Bypass on: busy drops when `reg_write`=1, with `fwd_rs1_data`=0x1234.
- ALU valid for 4 cycles while loads to `rd` 1, 2, 3 are offered on consecutive cycles → `mem_ready` goes 0 after 2 accepts. After the ALU burst, writes occur in the order 1, 2, then 3 (3 accepted once `mem_ready` returns).
- ALU result `rd`=0, data 0xFFFFFFFF → `reg_write` stays 0; `busy_rs1` with rs1=0 stays 0.
- Issue `rd`=9 in the same cycle an ALU result for `rd`=9 loads → `sb[9]` remains set; `busy` stays high after the write.
- `rst_n` low with 2 buffered loads and `reg_write`=1 → `reg_write`=0 asynchronously, `mem_ready`=1, all `busy`=0; no write occurs after reset release.

Source files
------------

// File: rtl/wb_stage_if.sv
// Writeback stage bus: issue, ALU and load result ports, decode hazard query and regfile write port.
// The forward outputs exist only when WB_BYPASS_EN is defined.
interface wb_stage_if #(
    parameter int XLEN = 32
);
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            mem_valid;
    logic            mem_ready;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            busy_rs1;
    logic            busy_rs2;
    logic            reg_write;
    logic [4:0]      write_register;
    logic [XLEN-1:0] write_data;
`ifdef WB_BYPASS_EN
    logic            fwd_rs1_valid;
    logic            fwd_rs2_valid;
    logic [XLEN-1:0] fwd_rs1_data;
    logic [XLEN-1:0] fwd_rs2_data;
`endif

    modport slave (
        input  issue_valid, issue_rd,
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        input  rs1, rs2,
        output busy_rs1, busy_rs2,
`ifdef WB_BYPASS_EN
        output fwd_rs1_valid, fwd_rs2_valid, fwd_rs1_data, fwd_rs2_data,
`endif
        output reg_write, write_register, write_data
    );

    modport master (
        output issue_valid, issue_rd,
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        output rs1, rs2,
        input  busy_rs1, busy_rs2,
`ifdef WB_BYPASS_EN
        input  fwd_rs1_valid, fwd_rs2_valid, fwd_rs1_data, fwd_rs2_data,
`endif
        input  reg_write, write_register, write_data
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: merges ALU and skid-buffered load results into one registered regfile write port,
// with a pending-register scoreboard for decode. Optional operand forwarding under WB_BYPASS_EN.
module wb_stage #(
    parameter int XLEN = 32
) (
    input logic   clk,
    input logic   rst_n,
    wb_stage_if.slave wb
);
    logic [4:0]      buf_rd   [2];
    logic [XLEN-1:0] buf_data [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;
    logic [31:0]     sb;

    logic            mem_accept;
    logic            push;
    logic            pop;
    logic            sel_valid;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [31:0]     sb_next;

    assign wb.mem_ready = (count < 2'd2);
    assign mem_accept   = wb.mem_valid && wb.mem_ready;

    // ALU always wins; a load competing with the ALU or queued behind older loads goes into the buffer.
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        sel_valid = 1'b0;
        sel_rd    = 5'd0;
        sel_data  = '0;
        if (wb.alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = wb.alu_rd;
            sel_data  = wb.alu_data;
            push      = mem_accept;
        end else if (count != 2'd0) begin
            sel_valid = 1'b1;
            sel_rd    = buf_rd[rd_ptr];
            sel_data  = buf_data[rd_ptr];
            pop       = 1'b1;
            push      = mem_accept;
        end else if (mem_accept) begin
            sel_valid = 1'b1;
            sel_rd    = wb.mem_rd;
            sel_data  = wb.mem_data;
        end
    end

    // A new issue overrides a completing write to the same register.
    always_comb begin
        sb_next = sb;
        if (sel_valid && sel_rd != 5'd0)
            sb_next[sel_rd] = 1'b0;
        if (wb.issue_valid && wb.issue_rd != 5'd0)
            sb_next[wb.issue_rd] = 1'b1;
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_rd[i]   <= 5'd0;
                buf_data[i] <= '0;
            end
            wr_ptr            <= 1'b0;
            rd_ptr            <= 1'b0;
            count             <= 2'd0;
            sb                <= 32'd0;
            wb.reg_write      <= 1'b0;
            wb.write_register <= 5'd0;
            wb.write_data     <= '0;
        end else begin
            if (push) begin
                buf_rd[wr_ptr]   <= wb.mem_rd;
                buf_data[wr_ptr] <= wb.mem_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count        <= count + {1'b0, push} - {1'b0, pop};
            sb           <= sb_next;
            wb.reg_write <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid) begin
                wb.write_register <= sel_rd;
                wb.write_data     <= sel_data;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign wb.fwd_rs1_valid = wb.reg_write && (wb.write_register == wb.rs1) && (wb.rs1 != 5'd0);
    assign wb.fwd_rs2_valid = wb.reg_write && (wb.write_register == wb.rs2) && (wb.rs2 != 5'd0);
    assign wb.fwd_rs1_data  = wb.write_data;
    assign wb.fwd_rs2_data  = wb.write_data;
    assign wb.busy_rs1      = (wb.rs1 != 5'd0) && sb[wb.rs1];
    assign wb.busy_rs2      = (wb.rs2 != 5'd0) && sb[wb.rs2];
`else
    // Without forwarding, the value being written this cycle is not yet readable from the regfile.
    assign wb.busy_rs1 = (wb.rs1 != 5'd0) &&
                         (sb[wb.rs1] || (wb.reg_write && wb.write_register == wb.rs1));
    assign wb.busy_rs2 = (wb.rs2 != 5'd0) &&
                         (sb[wb.rs2] || (wb.reg_write && wb.write_register == wb.rs2));
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus random traffic against a queue-based model.
module tb_wb_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_stage_if #(.XLEN(32)) wb ();
    wb_stage #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .wb(wb));

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t      pend_q[$];
    logic [4:0]  wr_log[$];
    logic        exp_rw;
    logic [4:0]  exp_wr;
    logic [31:0] exp_wd;
    logic [31:0] sb_m;
    int          checks = 0;
    int          errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic expBusy(input logic [4:0] rs);
`ifdef WB_BYPASS_EN
        return (rs != 0) && sb_m[rs];
`else
        return (rs != 0) && (sb_m[rs] || (exp_rw && exp_wr == rs));
`endif
    endfunction

    task automatic modelReset();
        pend_q.delete();
        exp_rw = 1'b0;
        exp_wr = 5'd0;
        exp_wd = 32'd0;
        sb_m   = 32'd0;
    endtask

    task automatic driveIdle();
        wb.issue_valid = 0; wb.issue_rd = 0;
        wb.alu_valid = 0; wb.alu_rd = 0; wb.alu_data = 0;
        wb.mem_valid = 0; wb.mem_rd = 0; wb.mem_data = 0;
    endtask

    // Drive one cycle of inputs, check the DUT against the model, then advance the model.
    task automatic applyStimulus(input logic iv, input logic [4:0] ird,
                                 input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                 input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                                 input logic [4:0] r1, input logic [4:0] r2);
        entry_t      e;
        logic        acc;
        logic        sv;
        logic [4:0]  srd;
        logic [31:0] sd;
        @(negedge clk);
        wb.issue_valid = iv; wb.issue_rd = ird;
        wb.alu_valid = av; wb.alu_rd = ard; wb.alu_data = ad;
        wb.mem_valid = mv; wb.mem_rd = mrd; wb.mem_data = md;
        wb.rs1 = r1; wb.rs2 = r2;
        #1;
        checkOutput("mem_ready", {31'd0, wb.mem_ready}, {31'd0, pend_q.size() < 2});
        checkOutput("reg_write", {31'd0, wb.reg_write}, {31'd0, exp_rw});
        if (exp_rw) begin
            checkOutput("write_register", {27'd0, wb.write_register}, {27'd0, exp_wr});
            checkOutput("write_data", wb.write_data, exp_wd);
        end
        if (wb.reg_write) wr_log.push_back(wb.write_register);
        checkOutput("busy_rs1", {31'd0, wb.busy_rs1}, {31'd0, expBusy(r1)});
        checkOutput("busy_rs2", {31'd0, wb.busy_rs2}, {31'd0, expBusy(r2)});
`ifdef WB_BYPASS_EN
        checkOutput("fwd_rs1_valid", {31'd0, wb.fwd_rs1_valid},
                    {31'd0, exp_rw && exp_wr == r1 && r1 != 0});
        checkOutput("fwd_rs2_valid", {31'd0, wb.fwd_rs2_valid},
                    {31'd0, exp_rw && exp_wr == r2 && r2 != 0});
        if (exp_rw && exp_wr == r1 && r1 != 0) checkOutput("fwd_rs1_data", wb.fwd_rs1_data, exp_wd);
        if (exp_rw && exp_wr == r2 && r2 != 0) checkOutput("fwd_rs2_data", wb.fwd_rs2_data, exp_wd);
`endif
        acc = mv && (pend_q.size() < 2);
        sv  = 1'b0;
        srd = 5'd0;
        sd  = 32'd0;
        if (av) begin
            sv = 1'b1; srd = ard; sd = ad;
        end else if (pend_q.size() > 0) begin
            e = pend_q.pop_front();
            sv = 1'b1; srd = e.rd; sd = e.data;
        end else if (acc) begin
            sv = 1'b1; srd = mrd; sd = md;
            acc = 1'b0;
        end
        if (acc) begin
            e.rd = mrd; e.data = md;
            pend_q.push_back(e);
        end
        exp_rw = sv && (srd != 0);
        if (exp_rw) begin
            exp_wr = srd;
            exp_wd = sd;
        end
        if (sv && srd != 0) sb_m[srd] = 1'b0;
        if (iv && ird != 0) sb_m[ird] = 1'b1;
    endtask

    task automatic idleCycle(input logic [4:0] r1, input logic [4:0] r2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    initial begin
        rst_n = 1'b0;
        driveIdle();
        wb.rs1 = 5'd3; wb.rs2 = 5'd0;
        modelReset();
        #12;
        checkOutput("rst_reg_write", {31'd0, wb.reg_write}, 32'd0);
        checkOutput("rst_write_register", {27'd0, wb.write_register}, 32'd0);
        checkOutput("rst_write_data", wb.write_data, 32'd0);
        checkOutput("rst_mem_ready", {31'd0, wb.mem_ready}, 32'd1);
        checkOutput("rst_busy_rs1", {31'd0, wb.busy_rs1}, 32'd0);
        rst_n = 1'b1;

        applyStimulus(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
        idleCycle(5, 0);
        idleCycle(5, 0);

        applyStimulus(1, 7, 0, 0, 0, 0, 0, 0, 7, 0);
        idleCycle(7, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 7, 32'h1234, 7, 0);
        idleCycle(7, 0);
        idleCycle(7, 0);

        wr_log.delete();
        applyStimulus(0, 0, 1, 0, 32'hA0, 1, 1, 32'h11, 1, 2);
        applyStimulus(0, 0, 1, 0, 32'hA1, 1, 2, 32'h22, 1, 2);
        applyStimulus(0, 0, 1, 0, 32'hA2, 1, 3, 32'h33, 3, 2);
        applyStimulus(0, 0, 1, 0, 32'hA3, 1, 3, 32'h33, 3, 2);
        applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'h33, 3, 2);
        applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'h33, 3, 2);
        idleCycle(3, 1);
        idleCycle(3, 1);
        idleCycle(3, 1);
        checkOutput("order_len", wr_log.size(), 32'd3);
        if (wr_log.size() == 3) begin
            checkOutput("order_0", {27'd0, wr_log[0]}, 32'd1);
            checkOutput("order_1", {27'd0, wr_log[1]}, 32'd2);
            checkOutput("order_2", {27'd0, wr_log[2]}, 32'd3);
        end

        applyStimulus(0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
        idleCycle(0, 0);
        idleCycle(0, 0);

        applyStimulus(1, 9, 0, 0, 0, 0, 0, 0, 9, 0);
        applyStimulus(1, 9, 1, 9, 32'h99, 0, 0, 0, 9, 0);
        idleCycle(9, 0);
        idleCycle(9, 0);
        applyStimulus(0, 0, 1, 9, 32'h999, 0, 0, 0, 9, 0);
        idleCycle(9, 0);

        applyStimulus(1, 4, 1, 6, 32'h66, 1, 1, 32'h111, 4, 6);
        applyStimulus(0, 0, 1, 6, 32'h67, 1, 2, 32'h222, 4, 6);
        @(posedge clk);
        #1;
        checkOutput("pre_rst_reg_write", {31'd0, wb.reg_write}, {31'd0, exp_rw});
        checkOutput("pre_rst_mem_ready", {31'd0, wb.mem_ready}, {31'd0, pend_q.size() < 2});
        driveIdle();
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_rst_reg_write", {31'd0, wb.reg_write}, 32'd0);
        checkOutput("async_rst_mem_ready", {31'd0, wb.mem_ready}, 32'd1);
        checkOutput("async_rst_busy_rs1", {31'd0, wb.busy_rs1}, 32'd0);
        checkOutput("async_rst_busy_rs2", {31'd0, wb.busy_rs2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_log.delete();
        for (int i = 0; i < 4; i++) idleCycle(4, 6);
        checkOutput("post_rst_writes", wr_log.size(), 32'd0);

        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)),
                          ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom,
                          ($urandom_range(0, 9) < 5), 5'($urandom_range(0, 7)), $urandom,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 4; i++) idleCycle(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
